// File: rtl/mito_pkg.sv
// -----------------------------------------------------------------------------
// mito_pkg
// Shared types for the layer sequencer and the datapath engines it drives:
//   layer_t      - layer-type codes stored in the program table
//   seq_state_t  - sequencer FSM states
//   phase_t      - phase encodings shared with the memory/compute engines
// -----------------------------------------------------------------------------
package mito_pkg;

  localparam int LAYER_TYPE_W = 2;

  typedef enum logic [LAYER_TYPE_W-1:0] {
    NONE  = 2'd0,
    CONV  = 2'd1,
    POOL  = 2'd2,
    FULLY = 2'd3
  } layer_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_READ,
    ST_COMP,
    ST_WRITE,
    ST_NEXT,
    ST_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_READ    = 3'd0,
    PH_COMP    = 3'd1,
    PH_WRITE   = 3'd2,
    PH_INIT    = 3'd3,
    PH_SUSPEND = 3'd4,
    PH_FINISH  = 3'd5
  } phase_t;

  // Engine-facing phase for a sequencer state; IDLE and NEXT carry no work.
  function automatic phase_t state_phase(input seq_state_t s);
    case (s)
      ST_INIT:   return PH_INIT;
      ST_READ:   return PH_READ;
      ST_COMP:   return PH_COMP;
      ST_WRITE:  return PH_WRITE;
      ST_FINISH: return PH_FINISH;
      default:   return PH_SUSPEND;
    endcase
  endfunction

endpackage

// File: rtl/layer_prog_table.sv
// -----------------------------------------------------------------------------
// layer_prog_table
// MAX_LAYERS x TYPE_W layer program register file.
//   clk, rst_n : clock, asynchronous active-low reset (all entries -> NONE)
//   i_we       : write strobe (already qualified by the sequencer)
//   i_waddr    : write address
//   i_wdata    : layer type to store
//   i_raddr    : combinational read address
//   o_rdata    : layer type at i_raddr (NONE for addresses past the depth)
// -----------------------------------------------------------------------------
module layer_prog_table
  import mito_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int TYPE_W     = LAYER_TYPE_W,
  parameter int IDX_W      = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [TYPE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [TYPE_W-1:0] o_rdata
);

  localparam logic [IDX_W:0]    LP_DEPTH = (IDX_W + 1)'(MAX_LAYERS);
  localparam logic [TYPE_W-1:0] LP_NONE  = TYPE_W'(NONE);

  logic [TYPE_W-1:0] r_entry [MAX_LAYERS];
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Non-power-of-two depths leave unused address codes; keep them inert.
  assign w_wr_ok = i_we && ({1'b0, i_waddr} < LP_DEPTH);
  assign w_rd_ok = ({1'b0, i_raddr} < LP_DEPTH);

  // NOTE: this small register file is reset on purpose: an unloaded entry
  // must read NONE so a stale program can never run after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) r_entry[i] <= LP_NONE;
    end else if (w_wr_ok) begin
      r_entry[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_entry[i_raddr] : LP_NONE;

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Steps through a host-loaded table of layer types and runs a
// READ -> COMP -> WRITE handshake with the engines for each layer.
//   start/num_layers : begin a program of num_layers layers (1-cycle pulse)
//   abort            : level, terminates a running program
//   cfg_we/addr/type : table write port, honoured only while idle
//   rd/comp/wr_req   : per-phase requests, held until the matching *_done
//   layer_type/idx   : active layer (NONE / 0 when idle)
//   busy             : INIT through FINISH
//   done/aborted/err : 1-cycle status pulses
// All outputs are registered.
// -----------------------------------------------------------------------------
module layer_sequencer
  import mito_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int TYPE_W     = LAYER_TYPE_W,
  parameter int IDX_W      = $clog2(MAX_LAYERS),
  parameter int CNT_W      = $clog2(MAX_LAYERS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_layers,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [TYPE_W-1:0] cfg_type,
  output logic              rd_req,
  input  logic              rd_done,
  output logic              comp_req,
  input  logic              comp_done,
  output logic              wr_req,
  input  logic              wr_done,
  output logic [TYPE_W-1:0] layer_type,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  localparam logic [CNT_W-1:0]  LP_MAX_CNT = CNT_W'(MAX_LAYERS);
  localparam logic [TYPE_W-1:0] LP_NONE    = TYPE_W'(NONE);

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_layer_idx;
  logic [TYPE_W-1:0] r_layer_type;
  logic              r_rd_req;
  logic              r_comp_req;
  logic              r_wr_req;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              r_err;

  logic [IDX_W-1:0]  w_raddr;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [CNT_W-1:0]  w_idx_inc_cnt;
  logic [TYPE_W-1:0] w_rdata;
  logic              w_tab_we;
  logic              w_start_ok;
  logic              w_last;

  // The write commits at the same edge the start is evaluated, so the start
  // check naturally sees the pre-write table[0].
  assign w_tab_we = cfg_we && (r_state == ST_IDLE);

  layer_prog_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .TYPE_W     (TYPE_W),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_tab_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_type),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_idx_inc     = r_layer_idx + IDX_W'(1);
  assign w_idx_inc_cnt = CNT_W'(r_layer_idx) + CNT_W'(1);

  // Single read port: entry 0 for the start check, the successor in NEXT,
  // otherwise the active layer.
  always_comb begin
    w_raddr = r_layer_idx;
    case (r_state)
      ST_IDLE: w_raddr = '0;
      ST_NEXT: w_raddr = w_idx_inc;
      default: w_raddr = r_layer_idx;
    endcase
  end

  assign w_start_ok = (num_layers != '0) && (num_layers <= LP_MAX_CNT) &&
                      (w_rdata != LP_NONE);

  // The count test comes first; at the last table slot the successor address
  // wraps, but the count is then necessarily exhausted.
  assign w_last = (w_idx_inc_cnt == r_count) || (w_rdata == LP_NONE);

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_layer_idx  <= '0;
      r_layer_type <= LP_NONE;
      r_rd_req     <= 1'b0;
      r_comp_req   <= 1'b0;
      r_wr_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= cfg_we && (r_state != ST_IDLE);

      if (abort && (r_state != ST_IDLE)) begin
        // Abort wins over any *_done sampled in the same cycle.
        r_state      <= ST_IDLE;
        r_rd_req     <= 1'b0;
        r_comp_req   <= 1'b0;
        r_wr_req     <= 1'b0;
        r_busy       <= 1'b0;
        r_layer_type <= LP_NONE;
        r_layer_idx  <= '0;
        r_aborted    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (w_start_ok) begin
                r_state      <= ST_INIT;
                r_busy       <= 1'b1;
                r_count      <= num_layers;
                r_layer_idx  <= '0;
                r_layer_type <= w_rdata;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_INIT: begin
            r_state      <= ST_READ;
            r_rd_req     <= 1'b1;
            r_layer_type <= w_rdata;
          end
          ST_READ: begin
            if (rd_done) begin
              r_state    <= ST_COMP;
              r_rd_req   <= 1'b0;
              r_comp_req <= 1'b1;
            end
          end
          ST_COMP: begin
            if (comp_done) begin
              r_state    <= ST_WRITE;
              r_comp_req <= 1'b0;
              r_wr_req   <= 1'b1;
            end
          end
          ST_WRITE: begin
            if (wr_done) begin
              r_state  <= ST_NEXT;
              r_wr_req <= 1'b0;
            end
          end
          ST_NEXT: begin
            if (w_last) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_READ;
              r_layer_idx  <= w_idx_inc;
              r_layer_type <= w_rdata;
              r_rd_req     <= 1'b1;
            end
          end
          ST_FINISH: begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_layer_type <= LP_NONE;
            r_layer_idx  <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_req     = r_rd_req;
  assign comp_req   = r_comp_req;
  assign wr_req     = r_wr_req;
  assign layer_type = r_layer_type;
  assign layer_idx  = r_layer_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign err        = r_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Expected behaviour is a per-cycle timeline built from the program table and
// randomly chosen engine latencies: INIT, then per layer READ/COMP/WRITE runs
// (latency+1 cycles each) and one NEXT cycle, then FINISH and idle.  The
// engine inputs are driven open-loop from the same timeline.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int MAX = 8;
  localparam int TW  = 2;
  localparam int IW  = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, cfg_we;
  logic [CW-1:0] num_layers;
  logic [IW-1:0] cfg_addr;
  logic [TW-1:0] cfg_type;
  logic          rd_req, rd_done, comp_req, comp_done, wr_req, wr_done;
  logic [TW-1:0] layer_type;
  logic [IW-1:0] layer_idx;
  logic          busy, done, aborted, err;

  layer_sequencer #(.MAX_LAYERS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_layers(num_layers), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_type(cfg_type), .rd_req(rd_req), .rd_done(rd_done),
    .comp_req(comp_req), .comp_done(comp_done), .wr_req(wr_req),
    .wr_done(wr_done), .layer_type(layer_type), .layer_idx(layer_idx),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_tab [MAX];

  // One cycle of expected outputs plus the inputs driven during that cycle.
  typedef struct {
    bit rd, cm, wr, busy, dn, ab, er;
    int ty, idx;
    bit d_rd, d_cm, d_wr, d_ab, d_st, d_cfg;
    int st_num, cfg_a, cfg_t;
  } cyc_t;

  cyc_t tl [$];
  int   first_idx [MAX][3];
  int   fin_idx   [MAX][3];

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: 0};
    return c;
  endfunction

  function automatic logic [11:0] obs_vec();
    return {rd_req, comp_req, wr_req, busy, done, aborted, err, layer_type, layer_idx};
  endfunction

  function automatic logic [11:0] exp_vec(input cyc_t c);
    logic [1:0] t;
    logic [2:0] x;
    t = 2'(c.ty);
    x = 3'(c.idx);
    return {c.rd, c.cm, c.wr, c.busy, c.dn, c.ab, c.er, t, x};
  endfunction

  // Stray dones for inactive phases and starts while busy must be ignored.
  function automatic void add_noise(inout cyc_t c, input int active);
    if (active != 0) c.d_rd = 1'($urandom_range(1, 0));
    if (active != 1) c.d_cm = 1'($urandom_range(1, 0));
    if (active != 2) c.d_wr = 1'($urandom_range(1, 0));
    if ($urandom_range(7, 0) == 0) begin
      c.d_st   = 1'b1;
      c.st_num = $urandom_range(MAX + 1, 0);
    end
  endfunction

  task automatic drive_idle();
    start = 0; abort = 0; cfg_we = 0; cfg_addr = '0; cfg_type = '0;
    rd_done = 0; comp_done = 0; wr_done = 0; num_layers = '0;
  endtask

  task automatic build_timeline(input int num, input int dmin, input int dmax, input bit noise);
    cyc_t c;
    int   k, d;
    tl.delete();
    k = 0;
    while (k < num && k < MAX && model_tab[k] != 0) k++;
    c = blank(); c.busy = 1; c.ty = model_tab[0];
    if (noise) add_noise(c, -1);
    tl.push_back(c);
    for (int l = 0; l < k; l++) begin
      for (int p = 0; p < 3; p++) begin
        d = $urandom_range(dmax, dmin);
        for (int j = 0; j <= d; j++) begin
          c = blank(); c.busy = 1; c.ty = model_tab[l]; c.idx = l;
          if (noise) add_noise(c, p);
          if (p == 0) c.rd = 1; else if (p == 1) c.cm = 1; else c.wr = 1;
          if (j == 0) first_idx[l][p] = tl.size();
          if (j == d) begin
            fin_idx[l][p] = tl.size();
            if (p == 0) c.d_rd = 1; else if (p == 1) c.d_cm = 1; else c.d_wr = 1;
          end
          tl.push_back(c);
        end
      end
      c = blank(); c.busy = 1; c.ty = model_tab[l]; c.idx = l;
      if (noise) add_noise(c, -1);
      tl.push_back(c);
    end
    c = blank(); c.busy = 1; c.dn = 1; c.ty = model_tab[k-1]; c.idx = k - 1;
    if (noise) add_noise(c, -1);
    tl.push_back(c);
    tl.push_back(blank());
  endtask

  task automatic apply_abort(input int a);
    cyc_t c;
    tl[a].d_ab = 1;
    while (tl.size() > a + 1) void'(tl.pop_back());
    c = blank(); c.ab = 1;
    tl.push_back(c);
    tl.push_back(blank());
  endtask

  task automatic apply_cfg(input int ci, input int a, input int t);
    tl[ci].d_cfg = 1; tl[ci].cfg_a = a; tl[ci].cfg_t = t;
    tl[ci+1].er = 1;
  endtask

  // Pulses start, then walks the timeline comparing outputs each cycle.
  task automatic run_timeline(input string name, input int num, input bit ab_start, input int rst_at);
    start = 1; num_layers = CW'(num); abort = ab_start;
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < tl.size(); i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(tl[i])) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b (rd cm wr busy done abrt err type idx)",
                 name, i, obs_vec(), exp_vec(tl[i]));
      end
      rd_done = tl[i].d_rd; comp_done = tl[i].d_cm; wr_done = tl[i].d_wr;
      abort = tl[i].d_ab; start = tl[i].d_st; num_layers = CW'(tl[i].st_num);
      cfg_we = tl[i].d_cfg; cfg_addr = IW'(tl[i].cfg_a); cfg_type = TW'(tl[i].cfg_t);
      if (i == rst_at) begin
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (obs_vec() !== 12'd0) begin
          n_fail++;
          $display("FAIL %s async reset: got %b expected 0", name, obs_vec());
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        for (int a = 0; a < MAX; a++) model_tab[a] = 0;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic write_entry(input int a, input int t);
    cfg_we = 1; cfg_addr = IW'(a); cfg_type = TW'(t);
    @(posedge clk); #1;
    cfg_we = 0;
    model_tab[a] = t;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_cfg_write err: got %b expected 0", err);
    end
  endtask

  task automatic test_illegal_start(input int num);
    start = 1; num_layers = CW'(num);
    @(posedge clk); #1;
    start = 0;
    n_checks++;
    if ({err, busy, rd_req, comp_req, wr_req, done} !== 6'b100000) begin
      n_fail++;
      $display("FAIL illegal_start(%0d) pulse: got %b expected 100000", num,
               {err, busy, rd_req, comp_req, wr_req, done});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_start(%0d) after: got %b expected 00", num, {err, busy});
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs_vec() !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0", obs_vec());
    end
  endtask

  // Table is all NONE here; the same-cycle write must not rescue the start.
  task automatic test_cfg_start_same_cycle();
    cfg_we = 1; cfg_addr = 0; cfg_type = 1; start = 1; num_layers = 1;
    @(posedge clk); #1;
    drive_idle();
    model_tab[0] = 1;
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL cfg_start_same_cycle: got %b expected 10", {err, busy});
    end
    @(posedge clk); #1;
    build_timeline(1, 0, 1, 0);
    run_timeline("post_write_run", 1, 0, -1);
  endtask

  task automatic test_basic();
    write_entry(0, 1); write_entry(1, 2); write_entry(2, 3);
    build_timeline(3, 1, 1, 0);
    run_timeline("basic_3layer", 3, 0, -1);
  endtask

  task automatic test_early_none();
    write_entry(0, 1); write_entry(1, 0); write_entry(2, 2);
    build_timeline(3, 0, 2, 1);
    run_timeline("early_none_abort_idle", 3, 1, -1);
  endtask

  task automatic test_abort();
    write_entry(0, 1); write_entry(1, 2); write_entry(2, 3);
    build_timeline(3, 0, 2, 1);
    apply_abort(fin_idx[1][1]);
    run_timeline("abort_on_comp_done", 3, 0, -1);
  endtask

  task automatic test_cfg_busy();
    write_entry(0, 1); write_entry(1, 2);
    build_timeline(2, 1, 2, 0);
    apply_cfg(first_idx[0][0], 1, 3);
    run_timeline("cfg_while_busy", 2, 0, -1);
    build_timeline(2, 0, 1, 0);
    run_timeline("write_was_dropped", 2, 0, -1);
    write_entry(1, 3);
    build_timeline(2, 0, 1, 0);
    run_timeline("rewritten_fully", 2, 0, -1);
  endtask

  task automatic test_reset_mid();
    write_entry(0, 1); write_entry(1, 2); write_entry(2, 3); write_entry(3, 1);
    build_timeline(4, 0, 2, 1);
    run_timeline("reset_mid_write", 4, 0, first_idx[1][2]);
    test_illegal_start(1);
    // Each run stops at the first still-NONE entry, proving it was cleared.
    for (int j = 1; j < MAX; j++) begin
      write_entry(j - 1, $urandom_range(3, 1));
      build_timeline(MAX, 0, 1, 0);
      run_timeline("table_cleared", MAX, 0, -1);
    end
  endtask

  task automatic test_random();
    int num, v, ci;
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < MAX; a++) begin
        v = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(3, 1);
        if (a == 0 && $urandom_range(7, 0) != 0) v = $urandom_range(3, 1);
        write_entry(a, v);
      end
      num = $urandom_range(MAX + 1, 0);
      if (num < 1 || num > MAX || model_tab[0] == 0) begin
        test_illegal_start(num);
      end else begin
        build_timeline(num, 0, 3, 1);
        if ($urandom_range(3, 0) == 0) apply_abort($urandom_range(tl.size() - 2, 0));
        if ($urandom_range(2, 0) == 0) begin
          ci = $urandom_range(tl.size() - 2, 0);
          if (tl[ci].busy) apply_cfg(ci, $urandom_range(MAX - 1, 0), $urandom_range(3, 0));
        end
        run_timeline("random", num, 1'($urandom_range(1, 0)), -1);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    for (int a = 0; a < MAX; a++) model_tab[a] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_cfg_start_same_cycle();
    test_basic();
    test_early_none();
    test_illegal_start(0);
    test_illegal_start(MAX + 1);
    test_abort();
    test_cfg_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
